// File: rtl/mem_port_arbiter_pkg.sv
// Shared CNN package: datapath widths, requester indices and arbiter state encoding.
package mem_port_arbiter_pkg;

    localparam int unsigned DATA_SZ = 16;
    localparam int unsigned ADDR_SZ = 16;

    // Requester slots on the shared memory port
    localparam int unsigned REQ_BIAS_LD = 0;
    localparam int unsigned REQ_BIAS_WR = 1;
    localparam int unsigned REQ_CONV    = 2;

    typedef enum logic {
        StIdle,
        StOwned
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin winner search: first requester with req high, starting after last_owner.
module mem_port_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] cand;

    // Walk NUM_REQ slots from last_owner+1 with wrap; last_owner itself is visited last
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = last_owner;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand == IDX_W'(NUM_REQ - 1)) begin
                cand = '0;
            end else begin
                cand = cand + 1'b1;
            end
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters, with
// optional grant locking capped at MAX_HOLD consecutive transfers.
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned DATA_SZ  = mem_port_arbiter_pkg::DATA_SZ,
    parameter int unsigned ADDR_SZ  = mem_port_arbiter_pkg::ADDR_SZ,
    parameter int unsigned MAX_HOLD = 25,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              lock,
    input  logic [NUM_REQ-1:0]              we,
    input  logic [NUM_REQ-1:0][ADDR_SZ-1:0] addr,
    input  logic [NUM_REQ-1:0][DATA_SZ-1:0] wdata,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              rvalid,
    output logic [DATA_SZ-1:0]              rdata,
    output logic [ADDR_SZ-1:0]              mem_addr,
    output logic [DATA_SZ-1:0]              mem_wdata,
    output logic                            mem_we,
    output logic                            mem_re,
    input  logic [DATA_SZ-1:0]              mem_rdata,
    output logic                            busy,
    output logic [IDX_W-1:0]                owner
);

    import mem_port_arbiter_pkg::*;

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  rvalid_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    last_owner_q;
    logic [HOLD_W-1:0]   hold_cnt_q;

    logic [NUM_REQ-1:0]  xfer;
    logic                xfer_any;
    logic                locked_xfer;
    logic                hold_room;
    logic                sole_req;
    logic                keep;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_index;

    assign xfer     = grant_q & req;
    assign xfer_any = |xfer;

    // Owner is the only granted bit, so req[owner] implies a transfer this cycle
    assign locked_xfer = (state_q == StOwned) && req[owner_q] && lock[owner_q];
    assign hold_room   = (32'(hold_cnt_q) + 32'd1) < MAX_HOLD;
    assign sole_req    = (req == grant_q);
    assign keep        = (locked_xfer && hold_room) || sole_req;

    assign grant  = grant_q;
    assign rvalid = rvalid_q;
    assign owner  = owner_q;
    assign busy   = |grant_q;
    assign rdata  = mem_rdata;

    mem_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .valid      (pick_valid),
        .index      (pick_index)
    );

    // RAM controls follow the owner only while it is actually transferring
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (xfer_any) begin
            mem_addr  = addr[owner_q];
            mem_wdata = wdata[owner_q];
            mem_we    = we[owner_q];
            mem_re    = ~we[owner_q];
        end
    end

    // Grant FSM with registered grant/owner/rvalid and the lock hold counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            rvalid_q     <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            hold_cnt_q   <= '0;
        end else begin
            rvalid_q <= xfer & ~we;
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q      <= StOwned;
                        grant_q      <= NUM_REQ'(1) << pick_index;
                        owner_q      <= pick_index;
                        last_owner_q <= pick_index;
                        hold_cnt_q   <= '0;
                    end
                end
                StOwned: begin
                    if (keep) begin
                        // Count only locked transfers; saturate when kept as sole requester
                        if (locked_xfer && hold_room) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end else if (!locked_xfer) begin
                            hold_cnt_q <= '0;
                        end
                    end else if (pick_valid) begin
                        grant_q      <= NUM_REQ'(1) << pick_index;
                        owner_q      <= pick_index;
                        last_owner_q <= pick_index;
                        hold_cnt_q   <= '0;
                    end else begin
                        state_q    <= StIdle;
                        grant_q    <= '0;
                        owner_q    <= '0;
                        hold_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single read, round-robin, lock cap,
// owner dropping req, reset mid-transfer and back-to-back reads.
module tb_mem_port_arbiter;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned DATA_SZ  = 16;
    localparam int unsigned ADDR_SZ  = 16;
    localparam int unsigned MAX_HOLD = 25;

    logic                            clk = 1'b0;
    logic                            reset;
    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ-1:0]              lock;
    logic [NUM_REQ-1:0]              we;
    logic [NUM_REQ-1:0][ADDR_SZ-1:0] addr;
    logic [NUM_REQ-1:0][DATA_SZ-1:0] wdata;
    logic [NUM_REQ-1:0]              grant;
    logic [NUM_REQ-1:0]              rvalid;
    logic [DATA_SZ-1:0]              rdata;
    logic [ADDR_SZ-1:0]              mem_addr;
    logic [DATA_SZ-1:0]              mem_wdata;
    logic                            mem_we;
    logic                            mem_re;
    logic [DATA_SZ-1:0]              mem_rdata;
    logic                            busy;
    logic [1:0]                      owner;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_SZ  (DATA_SZ),
        .ADDR_SZ  (ADDR_SZ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .grant     (grant),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    // RAM stand-in: read data is a fixed scramble of the address, one cycle after mem_re
    always_ff @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_addr ^ 16'hA5A5;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0]  exp_g [4];
        logic [15:0] exp_a [4];
        int          nwr;

        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_a = '{16'h0100, 16'h0200, 16'h0300, 16'h0100};

        // Reset state
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);

        // Single read by requester 0
        cyc();
        reset   = 1'b0;
        req     = 3'b001;
        addr[0] = 16'h0040;
        mid();
        chk("rd_idle_grant", 32'(grant), 0);
        chk("rd_idle_mem_re", 32'(mem_re), 0);
        cyc();
        mid();
        chk("rd_grant", 32'(grant), 1);
        chk("rd_mem_re", 32'(mem_re), 1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h0040);
        chk("rd_busy", 32'(busy), 1);
        chk("rd_owner", 32'(owner), 0);
        chk("rd_rvalid_early", 32'(rvalid), 0);
        cyc();
        req = '0;
        mid();
        chk("rd_rvalid", 32'(rvalid), 1);
        chk("rd_rdata", 32'(rdata), 32'hA5E5);
        chk("rd_mem_re_off", 32'(mem_re), 0);
        cyc();
        mid();
        chk("rd_idle_after", 32'(grant), 0);
        chk("rd_rvalid_once", 32'(rvalid), 0);

        // Round-robin with all three requesting, no lock
        do_reset();
        req  = 3'b111;
        addr = {16'h0300, 16'h0200, 16'h0100};
        mid();
        chk("rr_idle", 32'(grant), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mid();
            chk($sformatf("rr_grant%0d", i), 32'(grant), 32'(exp_g[i]));
            chk($sformatf("rr_addr%0d", i), 32'(mem_addr), 32'(exp_a[i]));
            if (i > 0) chk($sformatf("rr_rvalid%0d", i), 32'(rvalid), 32'(exp_g[i-1]));
        end
        cyc();
        req = '0;

        // Requester 1 locked writes against pending requester 0: cap at MAX_HOLD
        do_reset();
        req      = 3'b010;
        lock     = 3'b010;
        we       = 3'b010;
        addr[1]  = 16'h0800;
        wdata[1] = 16'hBEEF;
        cyc();
        req = 3'b011;
        nwr = 0;
        for (int n = 0; n < 26; n++) begin
            mid();
            if (n < 25) begin
                if (grant == 3'b010 && mem_we && mem_addr == 16'h0800 && mem_wdata == 16'hBEEF)
                    nwr++;
            end else begin
                chk("lock_handover_grant", 32'(grant), 1);
                chk("lock_handover_re", 32'(mem_re), 1);
            end
            cyc();
        end
        chk("lock_write_count", 32'(nwr), 25);
        req  = '0;
        lock = '0;
        we   = '0;

        // Requester 2 granted then drops req
        do_reset();
        req     = 3'b100;
        addr[2] = 16'h0300;
        cyc();
        req = 3'b001;
        mid();
        chk("drop_grant", 32'(grant), 4);
        chk("drop_mem_re", 32'(mem_re), 0);
        chk("drop_mem_we", 32'(mem_we), 0);
        chk("drop_mem_addr", 32'(mem_addr), 0);
        cyc();
        mid();
        chk("drop_next_grant", 32'(grant), 1);
        chk("drop_no_rvalid", 32'(rvalid), 0);
        cyc();
        req = '0;
        mid();
        chk("drop0_mem_re", 32'(mem_re), 0);
        cyc();
        mid();
        chk("drop0_idle_grant", 32'(grant), 0);
        chk("drop0_idle_busy", 32'(busy), 0);

        // Reset pulsed during a read by requester 0
        do_reset();
        req     = 3'b001;
        addr[0] = 16'h0040;
        cyc();
        mid();
        chk("rstmid_mem_re", 32'(mem_re), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_grant", 32'(grant), 0);
        chk("rstmid_mem_re_off", 32'(mem_re), 0);
        chk("rstmid_busy", 32'(busy), 0);
        cyc();
        chk("rstmid_no_rvalid", 32'(rvalid), 0);
        reset = 1'b0;
        req   = 3'b110;
        mid();
        chk("rstmid_still_idle", 32'(grant), 0);
        cyc();
        mid();
        chk("rstmid_first_grant", 32'(grant), 2);

        // Ten back-to-back reads by requester 0
        do_reset();
        req = 3'b001;
        cyc();
        for (int i = 0; i < 10; i++) begin
            addr[0] = 16'(32'h0040 + i);
            mid();
            chk($sformatf("b2b_grant%0d", i), 32'(grant), 1);
            chk($sformatf("b2b_addr%0d", i), 32'(mem_addr), 32'h0040 + i);
            if (i > 0) begin
                chk($sformatf("b2b_rvalid%0d", i), 32'(rvalid), 1);
                chk($sformatf("b2b_rdata%0d", i), 32'(rdata), (32'h0040 + i - 1) ^ 32'hA5A5);
            end
            cyc();
            if (i == 9) req = '0;
        end
        mid();
        chk("b2b_rvalid_last", 32'(rvalid), 1);
        chk("b2b_rdata_last", 32'(rdata), 32'h0049 ^ 32'hA5A5);
        chk("b2b_mem_re_off", 32'(mem_re), 0);
        cyc();
        mid();
        chk("b2b_rvalid_end", 32'(rvalid), 0);
        chk("b2b_idle", 32'(grant), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
